// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/next_PC.sv
// PC adder: PCsrc=0 gives PC + PC_INC, PCsrc=1 gives PC + ImmOp (both modulo 2^WIDTH).
// Purely combinational, no handshake.
module next_PC
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic             PCsrc,
  output logic [WIDTH-1:0] NextPC
);

  assign NextPC = PCsrc ? (PC + ImmOp) : (PC + WIDTH'(PC_INC));

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, runs the imem req/gnt/rvalid handshake, buffers one instruction for decode.
// One instruction per 3 cycles with zero-wait memory; decode backpressure holds the buffer in S_HOLD.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_imm,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             misalign_err
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_seq_pc;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_target_al;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_instr_pc;
  logic             r_instr_valid;
  logic             r_misalign_err;

  next_PC #(.WIDTH(WIDTH)) u_seq_pc (
    .PC     (r_pc),
    .ImmOp  ('0),
    .PCsrc  (1'b0),
    .NextPC (w_seq_pc)
  );

  next_PC #(.WIDTH(WIDTH)) u_br_pc (
    .PC     (br_pc),
    .ImmOp  (br_imm),
    .PCsrc  (1'b1),
    .NextPC (w_target)
  );

  assign w_target_al = {w_target[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (redirect_valid) w_state_nxt = imem_gnt ? S_DRAIN : S_REQ;
        else if (imem_gnt)  w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)   w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
        else if (imem_rvalid) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (redirect_valid || instr_ready) w_state_nxt = S_REQ;
      end
      // The outstanding response is the only thing left to retire here, so a
      // coincident redirect must not keep us waiting for an rvalid that never comes.
      S_DRAIN: begin
        if (imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (r_state == S_REQ);
    imem_addr = r_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc           <= RESET_VECTOR;
      r_instr        <= '0;
      r_instr_pc     <= '0;
      r_instr_valid  <= 1'b0;
      r_misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= w_target_al;
      if (w_target[1:0] != 2'b00) r_misalign_err <= 1'b1;
      if (r_state == S_HOLD)      r_instr_valid  <= 1'b0;
    end else begin
      if (r_state == S_WAIT && imem_rvalid) begin
        r_instr       <= imem_rdata;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
        r_pc          <= w_seq_pc;
      end
      if (r_state == S_HOLD && instr_ready) r_instr_valid <= 1'b0;
    end
  end

  assign instr_valid  = r_instr_valid;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: vector table of sequential fetches plus hand-written redirect/reset sequences.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_imm = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;
  bit seen_dead = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          gnt_wait;
    int          rv_wait;
    logic [31:0] exp_next;
  } vec_t;

  fetch_seq #(.WIDTH(32), .RESET_VECTOR(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .br_pc          (br_pc),
    .br_imm         (br_imm),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: imem_req not seen within 20 cycles, got %b expected 1", name, imem_req);
    end
  endtask

  // One fetch from REQ through to HOLD; the word is expected at decode.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int gw, input int rw);
    wait_req("fetch_req");
    chk("fetch_addr", imem_addr, a);
    for (int i = 0; i < gw; i++) begin
      step();
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, a);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_req_low", imem_req, 0);
    for (int i = 0; i < rw; i++) step();
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    sb_q.push_back('{data: d, pc: a});
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("hold_valid", instr_valid, 1);
  endtask

  task automatic redirect(input logic [31:0] p, input logic [31:0] imm);
    redirect_valid = 1'b1;
    br_pc          = p;
    br_imm         = imm;
    step();
    redirect_valid = 1'b0;
    br_pc          = '0;
    br_imm         = '0;
  endtask

  // Scoreboard: every decode handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got instr %h pc %h, expected none", instr, instr_pc);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_instr", instr, e.data);
        chk("sb_pc", instr_pc, e.pc);
      end
    end
    if (instr == 32'hDEADBEEF) seen_dead = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{addr: 32'h100, data: 32'h00A00093, gnt_wait: 0, rv_wait: 0, exp_next: 32'h104};
    vecs[1] = '{addr: 32'h104, data: 32'h11111111, gnt_wait: 4, rv_wait: 0, exp_next: 32'h108};
    vecs[2] = '{addr: 32'h108, data: 32'h22222222, gnt_wait: 1, rv_wait: 2, exp_next: 32'h10C};
    vecs[3] = '{addr: 32'h10C, data: 32'h33333333, gnt_wait: 0, rv_wait: 1, exp_next: 32'h110};

    #12;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_misalign", misalign_err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("idle_req", imem_req, 0);
    step();
    chk("req_after_idle", imem_req, 1);

    for (int i = 0; i < 4; i++) begin
      do_fetch(vecs[i].addr, vecs[i].data, vecs[i].gnt_wait, vecs[i].rv_wait);
      step();
      chk("next_req", imem_req, 1);
      chk("next_addr", imem_addr, vecs[i].exp_next);
    end

    // Redirect while waiting on rvalid: data must be dropped.
    wait_req("rdw_req");
    chk("rdw_addr", imem_addr, 32'h110);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect(32'h200, 32'hFFFF_FFF0);
    chk("drain_req", imem_req, 0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("drain_valid", instr_valid, 0);
    chk("drain_next_req", imem_req, 1);
    chk("drain_next_addr", imem_addr, 32'h1F0);
    do_fetch(32'h1F0, 32'h55555555, 0, 0);

    // Redirect and instr_ready together in HOLD.
    wait_req("hold_req");
    chk("hold_fetch_addr", imem_addr, 32'h1F4);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h44444444;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("hold_valid_pre", instr_valid, 1);
    redirect(32'h3F0, 32'h10);
    chk("flush_valid", instr_valid, 0);
    chk("flush_req", imem_req, 1);
    chk("flush_addr", imem_addr, 32'h400);
    do_fetch(32'h400, 32'h66666666, 0, 0);

    // Misaligned redirect while the request is still ungranted.
    wait_req("mis_req");
    chk("mis_pre_addr", imem_addr, 32'h404);
    chk("mis_pre_err", misalign_err, 0);
    redirect(32'h10, 32'h6);
    chk("mis_req_hold", imem_req, 1);
    chk("mis_addr", imem_addr, 32'h14);
    chk("mis_err", misalign_err, 1);
    do_fetch(32'h14, 32'h77777777, 0, 0);
    chk("mis_err_sticky", misalign_err, 1);

    // PC wrap from the top of the address space.
    wait_req("wrap_req");
    chk("wrap_pre_addr", imem_addr, 32'h18);
    redirect(32'hFFFF_FFF0, 32'hC);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h88888888, 0, 0);
    wait_req("wrap_next_req");
    chk("wrap_zero_addr", imem_addr, 32'h0);
    chk("wrap_err_unchanged", misalign_err, 1);

    // Asynchronous reset in S_WAIT, then a stale rvalid.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_addr", imem_addr, 32'h100);
    chk("arst_valid", instr_valid, 0);
    chk("arst_instr", instr, 0);
    chk("arst_instr_pc", instr_pc, 0);
    chk("arst_misalign", misalign_err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADBAD00;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("stale_valid", instr_valid, 0);
    chk("stale_instr", instr, 0);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 32'h100);
    do_fetch(32'h100, 32'h99999999, 0, 0);
    step();
    step();

    chk("sb_empty", sb_q.size(), 0);
    chk("deadbeef_never", seen_dead, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
